// File: rtl/dispatcher_pkg.sv
// Shared definitions for the dispatch stage: widths, sentinel values, the
// internal opcode map and the decode helpers that classify an opcode.
package dispatcher_pkg;

  localparam int DATA_LEN   = 32;
  localparam int ADDR_LEN   = 32;
  localparam int ROB_LEN    = 4;
  localparam int OPENUM_LEN = 6;
  localparam int TAG_LEN    = ROB_LEN + 1;

  // Tag 0 is never handed out by the ROB, so it doubles as "no dependency".
  localparam logic [TAG_LEN-1:0]  ZERO_ROB  = '0;
  localparam logic [DATA_LEN-1:0] ZERO_WORD = '0;

  // Loads and stores are kept contiguous so the LSB target is a range test.
  typedef enum logic [OPENUM_LEN-1:0] {
    OP_NOP   = 6'd0,
    OP_LUI   = 6'd1,  OP_AUIPC = 6'd2,  OP_JAL   = 6'd3,  OP_JALR  = 6'd4,
    OP_BEQ   = 6'd5,  OP_BNE   = 6'd6,  OP_BLT   = 6'd7,  OP_BGE   = 6'd8,
    OP_BLTU  = 6'd9,  OP_BGEU  = 6'd10,
    OP_LB    = 6'd11, OP_LH    = 6'd12, OP_LW    = 6'd13, OP_LBU   = 6'd14,
    OP_LHU   = 6'd15,
    OP_SB    = 6'd16, OP_SH    = 6'd17, OP_SW    = 6'd18,
    OP_ADDI  = 6'd19, OP_SLTI  = 6'd20, OP_SLTIU = 6'd21, OP_XORI  = 6'd22,
    OP_ORI   = 6'd23, OP_ANDI  = 6'd24, OP_SLLI  = 6'd25, OP_SRLI  = 6'd26,
    OP_SRAI  = 6'd27,
    OP_ADD   = 6'd28, OP_SUB   = 6'd29, OP_SLL   = 6'd30, OP_SLT   = 6'd31,
    OP_SLTU  = 6'd32, OP_XOR   = 6'd33, OP_SRL   = 6'd34, OP_SRA   = 6'd35,
    OP_OR    = 6'd36, OP_AND   = 6'd37
  } openum_e;

  localparam logic [OPENUM_LEN-1:0] OPENUM_NOP = OP_NOP;

  function automatic logic is_branch(input logic [OPENUM_LEN-1:0] op);
    return (op >= OP_BEQ) && (op <= OP_BGEU);
  endfunction

  function automatic logic is_store(input logic [OPENUM_LEN-1:0] op);
    return (op >= OP_SB) && (op <= OP_SW);
  endfunction

  // Memory operations go to the load/store buffer, everything else to the RS.
  function automatic logic is_ls(input logic [OPENUM_LEN-1:0] op);
    return (op >= OP_LB) && (op <= OP_SW);
  endfunction

  function automatic logic writes_rd(input logic [OPENUM_LEN-1:0] op);
    return (op != OPENUM_NOP) && !is_branch(op) && !is_store(op);
  endfunction

  function automatic logic uses_rs1(input logic [OPENUM_LEN-1:0] op);
    return (op != OPENUM_NOP) && (op != OP_LUI) && (op != OP_AUIPC) && (op != OP_JAL);
  endfunction

  // Only branches, stores and register-register ALU ops read rs2.
  function automatic logic uses_rs2(input logic [OPENUM_LEN-1:0] op);
    return is_branch(op) || is_store(op) || ((op >= OP_ADD) && (op <= OP_AND));
  endfunction

endpackage

// File: rtl/dsp_operand_fwd.sv
// Resolves one source operand: register file value, then ROB result, then
// the two CDB broadcasts (RS CDB first), else the operand keeps waiting on its tag.
module dsp_operand_fwd
  import dispatcher_pkg::*;
(
  input  logic                use_i,
  input  logic [TAG_LEN-1:0]  reg_q_i,
  input  logic [DATA_LEN-1:0] reg_v_i,
  input  logic                rob_ready_i,
  input  logic [DATA_LEN-1:0] rob_v_i,
  input  logic                rs_cdb_valid_i,
  input  logic [TAG_LEN-1:0]  rs_cdb_id_i,
  input  logic [DATA_LEN-1:0] rs_cdb_res_i,
  input  logic                ls_cdb_valid_i,
  input  logic [TAG_LEN-1:0]  ls_cdb_id_i,
  input  logic [DATA_LEN-1:0] ls_cdb_res_i,
  output logic [DATA_LEN-1:0] v_o,
  output logic [TAG_LEN-1:0]  q_o
);

  // Priority chain; an unused source resolves to a ready zero operand.
  always_comb begin
    v_o = ZERO_WORD;
    q_o = ZERO_ROB;
    if (use_i) begin
      if (reg_q_i == ZERO_ROB) begin
        v_o = reg_v_i;
      end else if (rob_ready_i) begin
        v_o = rob_v_i;
      end else if (rs_cdb_valid_i && (rs_cdb_id_i == reg_q_i)) begin
        v_o = rs_cdb_res_i;
      end else if (ls_cdb_valid_i && (ls_cdb_id_i == reg_q_i)) begin
        v_o = ls_cdb_res_i;
      end else begin
        q_o = reg_q_i;
      end
    end
  end

endmodule

// File: rtl/dispatcher.sv
// Single-entry dispatch stage: holds one decoded instruction, resolves its
// operands, allocates a ROB entry and hands it to the RS or the LSB.
module dispatcher
  import dispatcher_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ena_from_if,
  input  logic [OPENUM_LEN-1:0] openum_from_if,
  input  logic [4:0]            rd_from_if,
  input  logic [4:0]            rs1_from_if,
  input  logic [4:0]            rs2_from_if,
  input  logic [DATA_LEN-1:0]   imm_from_if,
  input  logic [ADDR_LEN-1:0]   pc_from_if,
  output logic [4:0]            rs1_to_reg,
  output logic [4:0]            rs2_to_reg,
  input  logic [DATA_LEN-1:0]   V1_from_reg,
  input  logic [DATA_LEN-1:0]   V2_from_reg,
  input  logic [TAG_LEN-1:0]    Q1_from_reg,
  input  logic [TAG_LEN-1:0]    Q2_from_reg,
  output logic [TAG_LEN-1:0]    Q1_to_rob,
  output logic [TAG_LEN-1:0]    Q2_to_rob,
  input  logic                  Q1_ready_from_rob,
  input  logic                  Q2_ready_from_rob,
  input  logic [DATA_LEN-1:0]   V1_result_from_rob,
  input  logic [DATA_LEN-1:0]   V2_result_from_rob,
  input  logic [TAG_LEN-1:0]    rob_id_from_rob,
  input  logic                  rob_full_from_rob,
  input  logic                  rs_full_from_rs,
  input  logic                  lsb_full_from_lsb,
  input  logic                  valid_from_rs_cdb,
  input  logic [TAG_LEN-1:0]    rob_id_from_rs_cdb,
  input  logic [DATA_LEN-1:0]   result_from_rs_cdb,
  input  logic                  valid_from_ls_cdb,
  input  logic [TAG_LEN-1:0]    rob_id_from_ls_cdb,
  input  logic [DATA_LEN-1:0]   result_from_ls_cdb,
  input  logic                  commit_jump_flag_from_rob,
  output logic                  ena_to_rs,
  output logic                  ena_to_lsb,
  output logic                  ena_to_rob,
  output logic                  ena_to_reg,
  output logic [OPENUM_LEN-1:0] openum_to_ex_units,
  output logic [DATA_LEN-1:0]   V1_out,
  output logic [DATA_LEN-1:0]   V2_out,
  output logic [DATA_LEN-1:0]   imm_out,
  output logic [TAG_LEN-1:0]    Q1_out,
  output logic [TAG_LEN-1:0]    Q2_out,
  output logic [TAG_LEN-1:0]    rob_id_out,
  output logic [ADDR_LEN-1:0]   pc_out,
  output logic [4:0]            rd_to_reg,
  output logic                  stall_to_if
);

  logic                  valid_q, valid_d;
  logic [OPENUM_LEN-1:0] openum_q, openum_d;
  logic [4:0]            rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [DATA_LEN-1:0]   imm_q, imm_d;
  logic [ADDR_LEN-1:0]   pc_q, pc_d;

  logic flush, to_lsb, blocked, issue, accept;

  assign flush       = commit_jump_flag_from_rob;
  assign to_lsb      = is_ls(openum_q);
  assign blocked     = rob_full_from_rob | (to_lsb ? lsb_full_from_lsb : rs_full_from_rs);
  assign stall_to_if = valid_q & blocked;
  assign issue       = valid_q & ~blocked & ~flush;
  // A draining stage accepts in the same cycle, giving one issue per cycle.
  assign accept      = ena_from_if & ~stall_to_if & ~flush;

  // Stage next-state: flush clears, accept loads, a lone issue empties.
  always_comb begin
    valid_d  = valid_q;
    openum_d = openum_q;
    rd_d     = rd_q;
    rs1_d    = rs1_q;
    rs2_d    = rs2_q;
    imm_d    = imm_q;
    pc_d     = pc_q;
    if (flush) begin
      valid_d  = 1'b0;
      openum_d = OPENUM_NOP;
      rd_d     = '0;
      rs1_d    = '0;
      rs2_d    = '0;
      imm_d    = ZERO_WORD;
      pc_d     = '0;
    end else if (accept) begin
      valid_d  = 1'b1;
      openum_d = openum_from_if;
      rd_d     = rd_from_if;
      rs1_d    = rs1_from_if;
      rs2_d    = rs2_from_if;
      imm_d    = imm_from_if;
      pc_d     = pc_from_if;
    end else if (issue) begin
      valid_d  = 1'b0;
    end
  end

  // Stage register with synchronous reset to an empty NOP.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q  <= 1'b0;
      openum_q <= OPENUM_NOP;
      rd_q     <= '0;
      rs1_q    <= '0;
      rs2_q    <= '0;
      imm_q    <= ZERO_WORD;
      pc_q     <= '0;
    end else begin
      valid_q  <= valid_d;
      openum_q <= openum_d;
      rd_q     <= rd_d;
      rs1_q    <= rs1_d;
      rs2_q    <= rs2_d;
      imm_q    <= imm_d;
      pc_q     <= pc_d;
    end
  end

  assign rs1_to_reg = rs1_q;
  assign rs2_to_reg = rs2_q;
  assign Q1_to_rob  = Q1_from_reg;
  assign Q2_to_rob  = Q2_from_reg;

  dsp_operand_fwd u_fwd1 (
    .use_i          (valid_q & uses_rs1(openum_q)),
    .reg_q_i        (Q1_from_reg),
    .reg_v_i        (V1_from_reg),
    .rob_ready_i    (Q1_ready_from_rob),
    .rob_v_i        (V1_result_from_rob),
    .rs_cdb_valid_i (valid_from_rs_cdb),
    .rs_cdb_id_i    (rob_id_from_rs_cdb),
    .rs_cdb_res_i   (result_from_rs_cdb),
    .ls_cdb_valid_i (valid_from_ls_cdb),
    .ls_cdb_id_i    (rob_id_from_ls_cdb),
    .ls_cdb_res_i   (result_from_ls_cdb),
    .v_o            (V1_out),
    .q_o            (Q1_out)
  );

  dsp_operand_fwd u_fwd2 (
    .use_i          (valid_q & uses_rs2(openum_q)),
    .reg_q_i        (Q2_from_reg),
    .reg_v_i        (V2_from_reg),
    .rob_ready_i    (Q2_ready_from_rob),
    .rob_v_i        (V2_result_from_rob),
    .rs_cdb_valid_i (valid_from_rs_cdb),
    .rs_cdb_id_i    (rob_id_from_rs_cdb),
    .rs_cdb_res_i   (result_from_rs_cdb),
    .ls_cdb_valid_i (valid_from_ls_cdb),
    .ls_cdb_id_i    (rob_id_from_ls_cdb),
    .ls_cdb_res_i   (result_from_ls_cdb),
    .v_o            (V2_out),
    .q_o            (Q2_out)
  );

  assign ena_to_rob         = issue;
  assign ena_to_rs          = issue & ~to_lsb;
  assign ena_to_lsb         = issue & to_lsb;
  assign ena_to_reg         = issue & writes_rd(openum_q) & (rd_q != 5'd0);
  assign rob_id_out         = valid_q ? rob_id_from_rob : ZERO_ROB;
  assign openum_to_ex_units = openum_q;
  assign imm_out            = imm_q;
  assign pc_out             = pc_q;
  assign rd_to_reg          = rd_q;

endmodule
